// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/D single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;

  typedef enum logic {REQ_IF, REQ_D} req_id_t;

  // Latency counter holds values 0..lat-1.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between IF and D.
// MEM_ARB_RR_EN: round-robin on a tie; otherwise D wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic    if_req_i,
  input  logic    d_req_i,
`ifdef MEM_ARB_RR_EN
  input  req_id_t last_i,
`endif
  output logic    any_o,
  output req_id_t pick_o
);

  assign any_o = if_req_i | d_req_i;

  always_comb begin
    pick_o = REQ_IF;
    if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      pick_o = (last_i == REQ_D) ? REQ_IF : REQ_D;
`else
      pick_o = REQ_D;
`endif
    end else if (d_req_i) begin
      pick_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between the fetch (IF) and data (D) ports.
// MEM_ARB_RR_EN selects round-robin tie-breaking (default: D over IF).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  req_id_t           owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic    any_req;
  req_id_t pick;

  // owner_q doubles as the last-winner register: it updates on every grant.
  arb_pick u_pick (
    .if_req_i (if_req),
    .d_req_i  (d_req),
`ifdef MEM_ARB_RR_EN
    .last_i   (owner_q),
`endif
    .any_o    (any_req),
    .pick_o   (pick)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d  = ACCESS;
          owner_d  = pick;
          mem_en_d = 1'b1;
          if (pick == REQ_D) begin
            d_gnt_d     = 1'b1;
            wr_d        = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            if_gnt_d   = 1'b1;
            wr_d       = 1'b0;
            mem_addr_d = if_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        // Counter reaching zero marks the cycle mem_rdata is valid.
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == REQ_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!wr_q) d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ_D;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
